// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter: FSM state codes, default baud divider, frame sizes.
// FIFO_UART_PARITY_EN selects 8E1 framing (parity state compiled in) instead of 8N1.
package fifo_uart_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;
  localparam logic [2:0] ST_PARITY  = 3'd5;
  localparam logic [2:0] ST_STOP    = 3'd6;

  // 20 MHz system clock / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 174;

  localparam int DATA_BITS         = 8;
  localparam int FRAME_BITS_8N1    = 10;
  localparam int FRAME_BITS_PARITY = 11;

`ifdef FIFO_UART_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and pulses tick on the last count; clear forces it back to 0.
module baud_tick_gen #(
  parameter int BAUD_DIV = 174
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO read port and sends each as a UART frame on tx (8N1, or 8E1
// when FIFO_UART_PARITY_EN is defined). state_dbg mirrors the FSM state register.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       empty_sig,
  input  logic [7:0] FIFO_read_data,
  output logic       read_req,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] state_dbg
);

  // FIFO handshake: read_req is a one-cycle strobe issued only from IDLE when empty_sig=0; the FIFO
  // presents the popped byte on the edge that samples the strobe, and RD_WAIT captures it one edge later.
  logic [2:0]           state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 read_req_q, read_req_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tick;
  logic                 baud_clear;
`ifdef FIFO_UART_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Keep the bit timer parked at zero until the start bit begins.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    read_req_d = 1'b0;
    busy_d     = busy_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
`ifdef FIFO_UART_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_sig) begin
          state_d    = ST_RD_REQ;
          read_req_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        shift_d   = FIFO_read_data;
`ifdef FIFO_UART_PARITY_EN
        parity_d  = ^FIFO_read_data;
`endif
        bit_idx_d = 3'd0;
        tx_d      = 1'b0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      read_req_q <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= 3'd0;
`ifdef FIFO_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      read_req_q <= read_req_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
`ifdef FIFO_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign read_req  = read_req_q;
  assign busy      = busy_q;
  assign tx_done   = (state_q == ST_STOP) && tick;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT, and a cycle-level UART receiver
// checks every frame against the byte order the FIFO handed out.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int B     = 4;
  localparam int DEPTH = 8;
`ifdef FIFO_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       empty_sig;
  logic       full_sig;
  logic [7:0] FIFO_read_data;
  logic       read_req, tx, busy, tx_done;
  logic [2:0] state_dbg;

  fifo_uart_tx #(.BAUD_DIV(B)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .empty_sig     (empty_sig),
    .FIFO_read_data(FIFO_read_data),
    .read_req      (read_req),
    .tx            (tx),
    .busy          (busy),
    .tx_done       (tx_done),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       bits [0:10];
  int n_checks = 0, n_fail = 0;
  int n_wr = 0, n_rr = 0, n_frames = 0, n_gap = 0, n_done = 0;
  int cyc = 0, rr_cyc = -100, done_cyc = -100, rr_since = 0, mon_cnt = 0;
  logic mon_active = 1'b0, prev_rr = 1'b0, b2b = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor at negedge, FIFO model update just after posedge.
  task automatic cycle();
    int idx, pos;
    logic [7:0] byte_v;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (read_req) begin
        n_rr++;
        rr_since++;
        check("rr_nonempty", 32'(fifo_q.size() != 0), 32'd1);
        check("rr_pulse", 32'(prev_rr), 32'd0);
        check("rr_outside_frame", 32'(mon_active), 32'd0);
        check("busy_at_rr", 32'(busy), 32'd1);
        rr_cyc = cyc;
      end
      prev_rr = read_req;
      if (tx_done) n_done++;
      if (cyc == done_cyc + 1) b2b = !empty_sig;
      if (!mon_active && tx == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        check("start_latency", 32'(cyc - rr_cyc), 32'd2);
        check("one_rr_per_frame", 32'(rr_since), 32'd1);
        rr_since = 0;
        if (b2b) begin
          check("b2b_idle_gap", 32'(cyc - done_cyc - 1), 32'd3);
          n_gap++;
          b2b = 1'b0;
        end
      end
      if (mon_active) begin
        idx = mon_cnt / B;
        pos = mon_cnt % B;
        if (pos == 0) bits[idx] = tx;
        else check("tx_stable", 32'(tx), 32'(bits[idx]));
        check("busy_in_frame", 32'(busy), 32'd1);
        check("tx_done_timing", 32'(tx_done), 32'(mon_cnt == NB * B - 1));
        if (mon_cnt == NB * B - 1) begin
          for (int k = 0; k < 8; k++) byte_v[k] = bits[1 + k];
          check("stop_bit", 32'(bits[NB-1]), 32'd1);
`ifdef FIFO_UART_PARITY_EN
          check("parity_bit", 32'(bits[9]), 32'(^byte_v));
`endif
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("frame_byte", 32'(byte_v), 32'(exp_q.pop_front()));
          mon_active = 1'b0;
          done_cyc = cyc;
          n_frames++;
        end else begin
          mon_cnt++;
        end
      end else begin
        check("tx_idle_high", 32'(tx), 32'd1);
        check("tx_done_idle", 32'(tx_done), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    if (prev_rr && rst_n && fifo_q.size() != 0) begin
      FIFO_read_data = fifo_q.pop_front();
      exp_q.push_back(FIFO_read_data);
    end
    if (wr_en) begin
      if (fifo_q.size() < DEPTH) begin
        fifo_q.push_back(wr_data);
        n_wr++;
      end
      wr_en = 1'b0;
    end
    empty_sig = (fifo_q.size() == 0);
    full_sig  = (fifo_q.size() == DEPTH);
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    cycle();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !mon_active && !busy) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (3) cycle();
  endtask

  task automatic wait_frame_pos(input int target, input int budget);
    int n = 0;
    while (!(mon_active && mon_cnt == target) && n < budget) begin
      cycle();
      n++;
    end
    check("frame_pos_in_budget", 32'(n < budget), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rr0, fr0, gap0, done0, nwrites;
    rst_n = 1'b0;
    empty_sig = 1'b1;
    full_sig = 1'b0;
    FIFO_read_data = 8'h00;
    repeat (2) cycle();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_read_req", 32'(read_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;

    // idle with an empty FIFO
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_read_req", 32'(read_req), 32'd0);
    end

    // single byte 0x05
    rr0 = n_rr; fr0 = n_frames; done0 = n_done;
    write_byte(8'h05);
    drain(200);
    check("single_rr_count", 32'(n_rr - rr0), 32'd1);
    check("single_frames", 32'(n_frames - fr0), 32'd1);
    check("single_tx_done", 32'(n_done - done0), 32'd1);
    check("single_empty_after", 32'(empty_sig), 32'd1);

    // back-to-back 100, 33, 99
    rr0 = n_rr; fr0 = n_frames; gap0 = n_gap;
    write_byte(8'd100);
    write_byte(8'd33);
    write_byte(8'd99);
    drain(600);
    check("b2b_rr_count", 32'(n_rr - rr0), 32'd3);
    check("b2b_frames", 32'(n_frames - fr0), 32'd3);
    check("b2b_gaps_seen", 32'(n_gap - gap0), 32'd2);

    // fill until full with incrementing data
    rr0 = n_rr; nwrites = n_wr;
    for (int i = 0; i < 40 && !full_sig; i++) write_byte(8'(8'h10 + i));
    check("fill_reached_full", 32'(full_sig), 32'd1);
    drain(2000);
    check("fill_rr_eq_writes", 32'(n_rr - rr0), 32'(n_wr - nwrites));

    // write during a frame
    fr0 = n_frames;
    write_byte(8'h5A);
    wait_frame_pos(4 * B, 200);
    write_byte(8'hA5);
    drain(400);
    check("mid_write_frames", 32'(n_frames - fr0), 32'd2);

    // parity reference bytes (decoder checks parity when compiled in)
    write_byte(8'h07);
    write_byte(8'h03);
    drain(400);

    // random bytes with random spacing
    for (int i = 0; i < 20; i++) begin
      if (!full_sig) write_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) cycle();
    end
    drain(3000);
    check("total_rr_eq_writes", 32'(n_rr), 32'(n_wr));

    // asynchronous reset in the middle of DATA
    rr0 = n_rr; fr0 = n_frames;
    write_byte(8'h3C);
    wait_frame_pos(3 * B + 1, 200);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_read_req", 32'(read_req), 32'd0);
    check("midrst_tx_done", 32'(tx_done), 32'd0);
    mon_active = 1'b0;
    prev_rr = 1'b0;
    rr_since = 0;
    b2b = 1'b0;
    exp_q.delete();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (30) cycle();
    check("midrst_no_reread", 32'(n_rr - rr0), 32'd1);
    check("midrst_no_frame", 32'(n_frames - fr0), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
